mioc_dma_arb: RTL

MIOC_DMA_ARB -- requirements
Module: mioc_dma_arb

---
 rtl/mioc_dma_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mioc_dma_arb.sv
// Arbitrates the Z80 bus between the CPU and 6801 DMA; the BUSRQ/BUSAK handshake gates the address buffers and the IS3 grant.
// Optional grant timeout with BLOCK state is compiled in with MIOC_DMA_TIMEOUT_EN.
module mioc_dma_arb #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic B_PHI,
    input  logic RST_N,
    input  logic DMA_N,
    input  logic BUSAK_N,
    output logic BUSRQ_N,
    output logic ADDRBUFEN_N,
    output logic IS3_N,
    output logic DMA_ACT,
    output logic DMA_TMO
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DIS   = 3'd2,
        GRANT = 3'd3,
        REL   = 3'd4,
        WACK  = 3'd5,
        BLOCK = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LIM = 8'(TMO_CYCLES);

    state_t     state_reg, state_next;
    logic [1:0] dma_sync_reg, busak_sync_reg;
    logic       dma_s, busak_s;
    logic       tmo_fire;
    logic       block_pending;
    logic       busrq_n_reg, addrbufen_n_reg, is3_n_reg, dma_act_reg;
    logic [3:0] out_next;

    // Idle-high synchronizers for both asynchronous handshake inputs
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            dma_sync_reg   <= 2'b11;
            busak_sync_reg <= 2'b11;
        end else begin
            dma_sync_reg   <= {dma_sync_reg[0], DMA_N};
            busak_sync_reg <= {busak_sync_reg[0], BUSAK_N};
        end
    end

    assign dma_s   = dma_sync_reg[1];
    assign busak_s = busak_sync_reg[1];

`ifdef MIOC_DMA_TIMEOUT_EN
    logic [7:0] cnt_reg;
    logic       tmo_reg;
    logic       block_pending_reg;

    assign tmo_fire      = (state_reg == REQ) && busak_s && (cnt_reg == TMO_LIM);
    assign block_pending = block_pending_reg;
    assign DMA_TMO       = tmo_reg;

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            cnt_reg           <= 8'd0;
            tmo_reg           <= 1'b0;
            block_pending_reg <= 1'b0;
        end else begin
            if (state_reg != REQ && state_next == REQ)
                cnt_reg <= 8'd0;
            else if (state_reg == REQ && cnt_reg != TMO_LIM)
                cnt_reg <= cnt_reg + 8'd1;
            if (tmo_fire)
                tmo_reg <= 1'b1;
            // Only the transaction that timed out detours through BLOCK
            if (tmo_fire)
                block_pending_reg <= 1'b1;
            else if (state_reg == WACK && busak_s)
                block_pending_reg <= 1'b0;
        end
    end
`else
    logic tmo_cfg_unused;
    assign tmo_cfg_unused = |TMO_LIM;
    assign tmo_fire       = 1'b0;
    assign block_pending  = 1'b0;
    assign DMA_TMO        = 1'b0;
`endif

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (!dma_s) state_next = REQ;
            // Grant beats both abort and timeout when they coincide
            REQ: begin
                if (!busak_s)
                    state_next = DIS;
                else if (tmo_fire || dma_s)
                    state_next = WACK;
            end
            DIS:   state_next = GRANT;
            GRANT: if (dma_s) state_next = REL;
            REL:   state_next = WACK;
            WACK:  if (busak_s) state_next = block_pending ? BLOCK : IDLE;
            BLOCK: if (dma_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // {BUSRQ_N, ADDRBUFEN_N, IS3_N, DMA_ACT} for the state being entered
    always_comb begin
        out_next = 4'b1010;
        case (state_next)
            IDLE:    out_next = 4'b1010;
            REQ:     out_next = 4'b0011;
            DIS:     out_next = 4'b0111;
            GRANT:   out_next = 4'b0101;
            REL:     out_next = 4'b0111;
            WACK:    out_next = 4'b1111;
            BLOCK:   out_next = 4'b1011;
            default: out_next = 4'b1010;
        endcase
    end

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            busrq_n_reg     <= 1'b1;
            addrbufen_n_reg <= 1'b0;
            is3_n_reg       <= 1'b1;
            dma_act_reg     <= 1'b0;
        end else begin
            busrq_n_reg     <= out_next[3];
            addrbufen_n_reg <= out_next[2];
            is3_n_reg       <= out_next[1];
            dma_act_reg     <= out_next[0];
        end
    end

    assign BUSRQ_N     = busrq_n_reg;
    assign ADDRBUFEN_N = addrbufen_n_reg;
    assign IS3_N       = is3_n_reg;
    assign DMA_ACT     = dma_act_reg;

endmodule
